// File: rtl/opcodes.sv
// Shared VeriRISC types: opcodes, instruction-cycle phases, run modes and
// the bundle of datapath strobes produced by the sequencer.
package opcodes;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   typedef enum logic [1:0] {
      HALTED   = 2'd0,
      RUNNING  = 2'd1,
      STEPPING = 2'd2
   } run_mode_t;

   typedef struct packed {
      logic sel;
      logic mem_rd;
      logic data_e;
      logic load_ir;
      logic inc_pc;
      logic load_pc;
      logic load_ac;
      logic mem_wr;
      logic instr_done;
   } strobes_t;

   localparam int CNT_W = 4;

   // Opcodes that read an operand from memory into the accumulator path.
   function automatic logic is_aluop(opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Combinational strobe table: maps the current phase and opcode to datapath
// enables. Pulse strobes are qualified by last_cycle of the phase.
module cpu_phase_decode
   import opcodes::*;
(
   input  phase_t   phase,
   input  opcode_t  opcode,
   input  logic     zero,
   input  logic     last_cycle,
   output strobes_t strobes
);

   logic alu;
   logic is_skz;
   logic is_jmp;
   logic is_sto;

   assign alu    = is_aluop(opcode);
   assign is_skz = (opcode == SKZ);
   assign is_jmp = (opcode == JMP);
   assign is_sto = (opcode == STO);

   always_comb begin
      strobes = '0;
      case (phase)
         INST_ADDR: begin
            strobes.sel = 1'b1;
         end
         INST_FETCH, IDLE: begin
            strobes.sel    = 1'b1;
            strobes.mem_rd = 1'b1;
         end
         INST_LOAD: begin
            strobes.sel     = 1'b1;
            strobes.mem_rd  = 1'b1;
            strobes.load_ir = last_cycle;
         end
         OP_ADDR: begin
            strobes.inc_pc = last_cycle;
         end
         OP_FETCH: begin
            strobes.mem_rd = alu;
         end
         ALU_OP: begin
            strobes.mem_rd  = alu;
            strobes.inc_pc  = last_cycle && is_skz && zero;
            strobes.load_pc = last_cycle && is_jmp;
            strobes.data_e  = is_sto;
         end
         STORE: begin
            strobes.mem_rd     = alu;
            strobes.load_ac    = last_cycle && alu;
            strobes.load_pc    = last_cycle && is_jmp;
            strobes.inc_pc     = last_cycle && is_jmp;
            strobes.data_e     = is_sto;
            strobes.mem_wr     = last_cycle && is_sto;
            strobes.instr_done = last_cycle;
         end
         default: strobes = '0;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Single-clock VeriRISC run-control sequencer: eight-phase instruction cycle,
// per-phase datapath strobes and debug run/step/halt control.
module cpu_sequencer
   import opcodes::*;
#(
   parameter int PHASE_CYCLES = 1,
   parameter bit START_HALTED = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   input  opcode_t   opcode,
   input  logic      zero,
   input  logic      run_req,
   input  logic      step_req,
   input  logic      halt_req,
   output logic      sel,
   output logic      mem_rd,
   output logic      data_e,
   output logic      load_ir,
   output logic      inc_pc,
   output logic      load_pc,
   output logic      load_ac,
   output logic      mem_wr,
   output logic      halt,
   output phase_t    phase,
   output logic      instr_done,
   output run_mode_t run_mode
);

   localparam run_mode_t RESET_MODE = START_HALTED ? HALTED : RUNNING;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PHASE_CYCLES - 1);

   run_mode_t         mode_q, mode_d;
   phase_t            phase_q, phase_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stop_q, stop_d;
   logic              last_cycle;
   logic              boundary;
   strobes_t          raw_strobes;
   strobes_t          strobes;

   assign last_cycle = (cnt_q == LAST_CNT);
   assign boundary   = (phase_q == STORE) && last_cycle;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= RESET_MODE;
         phase_q <= INST_ADDR;
         cnt_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         stop_q  <= stop_d;
      end
   end

   always_comb begin
      mode_d  = mode_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      stop_d  = stop_q;
      case (mode_q)
         HALTED: begin
            phase_d = INST_ADDR;
            cnt_d   = '0;
            stop_d  = 1'b0;
            // halt_req wins over both resume requests, step over run.
            if (!halt_req) begin
               if (step_req)     mode_d = STEPPING;
               else if (run_req) mode_d = RUNNING;
            end
         end
         RUNNING, STEPPING: begin
            if (halt_req || ((phase_q == OP_ADDR) && (opcode == HLT)))
               stop_d = 1'b1;
            if (last_cycle) begin
               cnt_d   = '0;
               phase_d = phase_t'(phase_q + 3'd1);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            // Stops only take effect between instructions, never mid-way.
            if (boundary && (stop_d || (mode_q == STEPPING))) begin
               mode_d = HALTED;
               stop_d = 1'b0;
            end
         end
         default: mode_d = HALTED;
      endcase
   end

   cpu_phase_decode u_decode (
      .phase      (phase_q),
      .opcode     (opcode),
      .zero       (zero),
      .last_cycle (last_cycle),
      .strobes    (raw_strobes)
   );

   assign strobes    = (!rst && (mode_q != HALTED)) ? raw_strobes : '0;

   assign sel        = strobes.sel;
   assign mem_rd     = strobes.mem_rd;
   assign data_e     = strobes.data_e;
   assign load_ir    = strobes.load_ir;
   assign inc_pc     = strobes.inc_pc;
   assign load_pc    = strobes.load_pc;
   assign load_ac    = strobes.load_ac;
   assign mem_wr     = strobes.mem_wr;
   assign instr_done = strobes.instr_done;
   assign halt       = (mode_q == HALTED);
   assign phase      = phase_q;
   assign run_mode   = mode_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (1 cycle/phase free-running, and
// 4 cycles/phase starting halted) checked against an instruction-level model.
module tb_cpu_sequencer;
   import opcodes::*;

   localparam int PC0 = 1;
   localparam int PC1 = 4;
   localparam int M_HALT = 0;
   localparam int M_RUN  = 1;
   localparam int M_STEP = 2;

   logic      clk = 1'b0;
   logic      rst_i[2];
   opcode_t   opc[2];
   logic      zero_i[2], run_r[2], step_r[2], halt_r[2];
   logic      sel_w[2], mem_rd_w[2], data_e_w[2], load_ir_w[2], inc_pc_w[2];
   logic      load_pc_w[2], load_ac_w[2], mem_wr_w[2], halt_w[2], done_w[2];
   phase_t    phase_w[2];
   run_mode_t mode_w[2];

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;

   int  m_mode[2] = '{M_RUN, M_HALT};
   int  m_t[2]    = '{0, 0};
   bit  m_stop[2] = '{1'b0, 1'b0};

   typedef struct {
      logic [31:0] sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, done, halt;
      logic [23:0] ph;
   } rec_t;

   always #5 clk = ~clk;

   cpu_sequencer #(.PHASE_CYCLES(PC0), .START_HALTED(1'b0)) u0 (
      .clk(clk), .rst(rst_i[0]), .opcode(opc[0]), .zero(zero_i[0]),
      .run_req(run_r[0]), .step_req(step_r[0]), .halt_req(halt_r[0]),
      .sel(sel_w[0]), .mem_rd(mem_rd_w[0]), .data_e(data_e_w[0]),
      .load_ir(load_ir_w[0]), .inc_pc(inc_pc_w[0]), .load_pc(load_pc_w[0]),
      .load_ac(load_ac_w[0]), .mem_wr(mem_wr_w[0]), .halt(halt_w[0]),
      .phase(phase_w[0]), .instr_done(done_w[0]), .run_mode(mode_w[0])
   );

   cpu_sequencer #(.PHASE_CYCLES(PC1), .START_HALTED(1'b1)) u1 (
      .clk(clk), .rst(rst_i[1]), .opcode(opc[1]), .zero(zero_i[1]),
      .run_req(run_r[1]), .step_req(step_r[1]), .halt_req(halt_r[1]),
      .sel(sel_w[1]), .mem_rd(mem_rd_w[1]), .data_e(data_e_w[1]),
      .load_ir(load_ir_w[1]), .inc_pc(inc_pc_w[1]), .load_pc(load_pc_w[1]),
      .load_ac(load_ac_w[1]), .mem_wr(mem_wr_w[1]), .halt(halt_w[1]),
      .phase(phase_w[1]), .instr_done(done_w[1]), .run_mode(mode_w[1])
   );

   function automatic int pc(int i);
      return (i == 0) ? PC0 : PC1;
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Strobes a running instruction must show: {sel,mem_rd,data_e,load_ir,
   // inc_pc,load_pc,load_ac,mem_wr,instr_done}.
   function automatic logic [8:0] exp_strobes(int ph, opcode_t op, logic z, bit last);
      bit alu;
      logic [8:0] s;
      alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
      s[8] = (ph <= 3);
      s[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      s[6] = (ph >= 6) && (op == STO);
      s[5] = last && (ph == 2);
      s[4] = last && ((ph == 4) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP));
      s[3] = last && (ph >= 6) && (op == JMP);
      s[2] = last && (ph == 7) && alu;
      s[1] = last && (ph == 7) && (op == STO);
      s[0] = last && (ph == 7);
      return s;
   endfunction

   function automatic logic [12:0] model_out(int i);
      logic [8:0] s;
      int ph;
      ph = m_t[i] / pc(i);
      s = exp_strobes(ph, opc[i], zero_i[i], (m_t[i] % pc(i)) == pc(i) - 1);
      if (rst_i[i] || m_mode[i] == M_HALT) s = '0;
      return {m_mode[i] == M_HALT, 3'(ph), s};
   endfunction

   function automatic logic [12:0] act_out(int i);
      return {halt_w[i], 3'(phase_w[i]), sel_w[i], mem_rd_w[i], data_e_w[i],
              load_ir_w[i], inc_pc_w[i], load_pc_w[i], load_ac_w[i],
              mem_wr_w[i], done_w[i]};
   endfunction

   // Instruction-level model: m_t counts cycles into the current instruction.
   function automatic void model_step(int i);
      if (rst_i[i]) begin
         m_mode[i] = (i == 0) ? M_RUN : M_HALT;
         m_t[i]    = 0;
         m_stop[i] = 1'b0;
      end else if (m_mode[i] == M_HALT) begin
         if (!halt_r[i]) begin
            if (step_r[i])     m_mode[i] = M_STEP;
            else if (run_r[i]) m_mode[i] = M_RUN;
         end
      end else begin
         if (halt_r[i]) m_stop[i] = 1'b1;
         if (m_t[i] / pc(i) == 4 && opc[i] == HLT) m_stop[i] = 1'b1;
         if (m_t[i] == 8 * pc(i) - 1) begin
            m_t[i] = 0;
            if (m_stop[i] || m_mode[i] == M_STEP) begin
               m_mode[i] = M_HALT;
               m_stop[i] = 1'b0;
            end
         end else begin
            m_t[i] = m_t[i] + 1;
         end
      end
   endfunction

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++)
            chk($sformatf("cycle_dut%0d", i), 32'(act_out(i)), 32'(model_out(i)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting at an INST_ADDR cycle; optional halt_req
   // pulse at cycle hr_k. Records each strobe per cycle as a bit mask.
   task automatic run_instr(input int i, input opcode_t op, input logic z,
                            input int hr_k, output rec_t r);
      int n;
      n = 8 * pc(i);
      r = '{default: '0};
      opc[i]    = op;
      zero_i[i] = z;
      for (int k = 0; k < n; k++) begin
         if (k == hr_k) halt_r[i] = 1'b1;
         @(negedge clk);
         r.sel[k]     = sel_w[i];
         r.mem_rd[k]  = mem_rd_w[i];
         r.load_ir[k] = load_ir_w[i];
         r.inc_pc[k]  = inc_pc_w[i];
         r.load_pc[k] = load_pc_w[i];
         r.load_ac[k] = load_ac_w[i];
         r.mem_wr[k]  = mem_wr_w[i];
         r.data_e[k]  = data_e_w[i];
         r.done[k]    = done_w[i];
         r.halt[k]    = halt_w[i];
         if (k % pc(i) == 0) r.ph[3*(k/pc(i)) +: 3] = phase_w[i];
         tick();
         halt_r[i] = 1'b0;
      end
   endtask

   initial begin
      rec_t r;
      int   good;
      for (int i = 0; i < 2; i++) begin
         rst_i[i] = 1'b1; opc[i] = ADD; zero_i[i] = 1'b0;
         run_r[i] = 1'b0; step_r[i] = 1'b0; halt_r[i] = 1'b0;
      end

      // Reset state
      @(posedge clk);
      @(negedge clk);
      chk("rst_halt_dut0", 32'(halt_w[0]), 32'd0);
      chk("rst_halt_dut1", 32'(halt_w[1]), 32'd1);
      chk("rst_phase_dut0", 32'(phase_w[0]), 32'd0);
      chk("rst_strobes_dut0", 32'(act_out(0) & 13'h1FF), 32'd0);
      chk_en = 1'b1;
      tick();
      rst_i[0] = 1'b0;
      rst_i[1] = 1'b0;

      // Free-running instructions on dut0
      run_instr(0, ADD, 1'b0, -1, r);
      chk("add_sel", r.sel, 32'h0F);
      chk("add_mem_rd", r.mem_rd, 32'hEE);
      chk("add_load_ir", r.load_ir, 32'h04);
      chk("add_inc_pc", r.inc_pc, 32'h10);
      chk("add_load_ac", r.load_ac, 32'h80);
      chk("add_done", r.done, 32'h80);
      run_instr(0, SKZ, 1'b1, -1, r);
      chk("skz1_phases", 32'(r.ph), 32'(24'o76543210));
      chk("skz1_inc_pc", r.inc_pc, 32'h50);
      run_instr(0, SKZ, 1'b0, -1, r);
      chk("skz0_inc_pc", r.inc_pc, 32'h10);
      run_instr(0, STO, 1'b0, -1, r);
      chk("sto_data_e", r.data_e, 32'hC0);
      chk("sto_mem_wr", r.mem_wr, 32'h80);
      run_instr(0, HLT, 1'b0, -1, r);
      chk("hlt_done", r.done, 32'h80);
      chk("hlt_not_halted_yet", r.halt, 32'h0);
      good = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (halt_w[0] && phase_w[0] == INST_ADDR && (act_out(0) & 13'h1FF) == 0) good++;
         tick();
      end
      chk("hlt_quiet_cycles", 32'(good), 32'd20);

      // halt_req beats step_req while halted
      halt_r[0] = 1'b1; step_r[0] = 1'b1;
      tick();
      halt_r[0] = 1'b0; step_r[0] = 1'b0;
      @(negedge clk);
      chk("halt_over_step", 32'(halt_w[0]), 32'd1);
      tick();

      // Resume
      opc[0] = ADD;
      run_r[0] = 1'b1;
      tick();
      run_r[0] = 1'b0;
      @(negedge clk);
      chk("run_resume", {30'd0, halt_w[0], sel_w[0]}, 32'b01);
      tick();
      repeat (7) tick();

      // halt_req during OP_FETCH on a JMP
      run_instr(0, JMP, 1'b0, 5, r);
      chk("jmp_load_pc", r.load_pc, 32'hC0);
      chk("jmp_inc_pc", r.inc_pc, 32'h90);
      @(negedge clk);
      chk("jmp_then_halt", {28'd0, halt_w[0], 3'(phase_w[0])}, 32'h8);
      tick();

      // dut1: simultaneous step+run gives one stepped instruction
      step_r[1] = 1'b1; run_r[1] = 1'b1;
      tick();
      step_r[1] = 1'b0; run_r[1] = 1'b0;
      run_instr(1, ADD, 1'b0, -1, r);
      chk("step_phases", 32'(r.ph), 32'(24'o76543210));
      chk("step_halt", r.halt, 32'h0);
      chk("step_done", r.done, 32'h8000_0000);
      chk("pc4_sel", r.sel, 32'h0000_FFFF);
      chk("pc4_load_ir", r.load_ir, 32'h0000_0800);
      chk("pc4_inc_pc", r.inc_pc, 32'h0008_0000);
      chk("pc4_load_ac", r.load_ac, 32'h8000_0000);
      @(negedge clk);
      chk("step_rehalted", 32'(halt_w[1]), 32'd1);
      tick();

      // Reset on the last STORE cycle of a STO
      opc[1] = STO;
      run_r[1] = 1'b1;
      tick();
      run_r[1] = 1'b0;
      repeat (31) tick();
      rst_i[1] = 1'b1;
      @(negedge clk);
      chk("rst_phase_store", 32'(phase_w[1]), 32'd7);
      chk("rst_no_mem_wr", {29'd0, mem_wr_w[1], done_w[1], data_e_w[1]}, 32'd0);
      tick();
      rst_i[1] = 1'b0;
      @(negedge clk);
      chk("after_rst", {28'd0, halt_w[1], 3'(phase_w[1])}, 32'h8);
      tick();

      // Randomized traffic; opcode only changes before OP_ADDR
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            rst_i[i]  = ($urandom_range(0, 599) == 0);
            run_r[i]  = ($urandom_range(0, 19) == 0);
            step_r[i] = ($urandom_range(0, 19) == 0);
            halt_r[i] = ($urandom_range(0, 29) == 0);
            zero_i[i] = 1'($urandom_range(0, 1));
            if (m_mode[i] == M_HALT || m_t[i] / pc(i) < 4)
               opc[i] = opcode_t'($urandom_range(0, 7));
         end
         tick();
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Single-clock run-control sequencer for the VeriRISC CPU datapath (PC, IR, accumulator, ALU, 32×8 memory). It replaces the derived multi-clock scheme (`control_clk`, `clk`, `fetch`, `alu_clk`) with one clock plus per-phase strobes. It steps through the eight-phase instruction cycle, decodes `opcode`/`zero` into datapath enables, and adds debug run/step/halt control. It sits between the IR/ALU outputs and every datapath load enable.

## Interface
- `PHASE_CYCLES`, default 1: clock cycles per phase; legal values are 1 to 15.
- `START_HALTED`, default 0: run mode after reset. 1 means HALTED, 0 means RUNNING.

- `clk` input 1: the only clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 3 (`opcode_t`): current IR opcode.
- `zero` input 1: accumulator-is-zero flag from the ALU.
- `run_req` input 1: one-cycle pulse; resume free-running execution.
- `step_req` input 1: one-cycle pulse; execute exactly one instruction.
- `halt_req` input 1: one-cycle pulse; stop at the next instruction boundary.
- `sel` output 1: address mux selects PC (level).
- `mem_rd` output 1: memory read (level).
- `data_e` output 1: accumulator drives the data bus (level).
- `load_ir` output 1: IR load enable (pulse).
- `inc_pc` output 1: PC increment enable (pulse).
- `load_pc` output 1: PC load enable (pulse).
- `load_ac` output 1: accumulator load enable (pulse).
- `mem_wr` output 1: memory write enable (pulse).
- `halt` output 1: high while in HALTED.
- `phase` output 3 (`phase_t`): current phase.
- `instr_done` output 1: one-cycle pulse on the last cycle of STORE.

## Operation
- Phase order: INST_ADDR → INST_FETCH → INST_LOAD → IDLE → OP_ADDR → OP_FETCH → ALU_OP → STORE → INST_ADDR.
- A phase advances after `PHASE_CYCLES` cycles, counted by an internal counter.
- Run-mode FSM states:
  - HALTED: phase frozen at INST_ADDR and all strobes 0.
  - RUNNING: phases advance continuously.
  - STEPPING: one instruction runs, then the FSM returns to HALTED.
- In HALTED: `run_req` → RUNNING and `step_req` → STEPPING.
  - When requests coincide, priority is `halt_req` > `step_req` > `run_req`. A `halt_req` in HALTED is ignored.
- In RUNNING, `halt_req` sets a sticky `stop_pending` flag. It is honored on the STORE→INST_ADDR transition (→ HALTED) and never truncates an instruction.
- `run_req` and `step_req` are ignored outside HALTED.
- HLT opcode: decoded in OP_ADDR (`halt` is not yet asserted). The instruction completes its remaining phases, then the FSM enters HALTED at the boundary.
- ALUOP is defined as ADD, AND, XOR or LDA.
- Strobes per phase (all are 0 unless listed):
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `mem_rd`.
  - INST_LOAD: `sel`, `mem_rd`, `load_ir`.
  - IDLE: `sel`, `mem_rd`.
  - OP_ADDR: `inc_pc`.
  - OP_FETCH: `mem_rd` if ALUOP.
  - ALU_OP:
    - `mem_rd` if ALUOP.
    - `inc_pc` if SKZ and `zero`.
    - `load_pc` if JMP.
    - `data_e` if STO.
  - STORE:
    - `mem_rd` if ALUOP.
    - `load_ac` if ALUOP.
    - `load_pc` if JMP.
    - `inc_pc` if JMP.
    - `data_e` if STO.
    - `mem_wr` if STO.
- Level strobes (`sel`, `mem_rd`, `data_e`) are held for the whole phase.
- Pulse strobes (`load_ir`, `inc_pc`, `load_pc`, `load_ac`, `mem_wr`, `instr_done`) are asserted only on the phase's last cycle.
- `zero` is sampled on that same cycle.
- All strobes are forced to 0 while `halt` = 1.
- Reset values:
  - phase = INST_ADDR and cycle counter = 0.
  - `stop_pending` = 0.
  - Mode per `START_HALTED`, so `halt` = `START_HALTED`.
  - All strobes and `instr_done` = 0 during reset.

## Timing
- Phase, mode and counter are registered. All outputs are Moore-decoded from registered state plus the `opcode`/`zero` inputs, with no extra register stage.
- Mode change latency:
  - A request sampled at edge N changes the mode at N+1.
  - The first INST_ADDR cycle with `sel` = 1 is N+1.
- One instruction lasts 8×`PHASE_CYCLES` cycles. Back-to-back instructions have no gap.
- After `rst` deassertion with `START_HALTED` = 0, INST_ADDR (with `sel`) is active on the first cycle.
- `rst` mid-instruction: no pulse strobe fires on the reset cycle. The next cycle is INST_ADDR, cycle 0.
- The cycle counter wraps to 0 on every phase advance. The phase wraps STORE→INST_ADDR.
- `opcode` must be stable from OP_ADDR through STORE. It is guaranteed by the IR holding its value.

## Structure
- Add `phase_t` (3-bit enum of the eight phases) and `run_mode_t` (HALTED/RUNNING/STEPPING) to the shared `opcodes` package, alongside `opcode_t`.
- One sub-module, `cpu_phase_decode`: a purely combinational strobe table with inputs `phase`, `opcode`, `zero`, `last_cycle`. `cpu_sequencer` holds the FSM, counter and gating.

## Test plan
- `START_HALTED`=0, `PHASE_CYCLES`=1, opcode ADD → over cycles 0–7: `sel` on cycles 0–3, `load_ir` on cycle 2, `inc_pc` on cycle 4, `load_ac` and `instr_done` on cycle 7; next INST_ADDR on cycle 8.
- SKZ with `zero`=1 → two `inc_pc` pulses (cycles 4 and 6). SKZ with `zero`=0 → exactly one. STO → `data_e` on cycles 6–7 and a single `mem_wr` on cycle 7.
- HLT → instruction finishes, `halt`=1 from cycle 8 with phase=INST_ADDR and all strobes 0 for 20 cycles. `run_req` → `halt`=0 and `sel`=1 on the next cycle.
- `START_HALTED`=1, `step_req` → exactly 8 phases, one `instr_done`, then `halt`=1. A simultaneous `step_req`+`run_req` yields a single step.
- `halt_req` during OP_FETCH while RUNNING with opcode JMP → `load_pc` and `inc_pc` still pulse in STORE, then `halt`=1 at the boundary.
- `PHASE_CYCLES`=4 → each phase lasts 4 cycles and pulses appear only on the 4th. `rst` asserted on STORE cycle 3 with STO → no `mem_wr`; phase=INST_ADDR after reset.
